// File: rtl/twiddle_seq_gen_if.sv
// Twiddle stream interface: valid/ready beat carrying one complex twiddle
// factor, its exponent k and an end-of-stage marker.
interface twiddle_seq_gen_if #(
  parameter int WIDTH = 9,
  parameter int KW    = 6
) ();
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_re;
  logic [WIDTH-1:0] out_im;
  logic [KW-1:0]    out_k;
  logic             out_last;

  modport master (
    output out_valid, out_re, out_im, out_k, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_re, out_im, out_k, out_last,
    output out_ready
  );
endinterface

// File: rtl/twiddle_seq_gen.sv
// Sequenced twiddle-factor source for a radix-2 DIT FFT. A quarter-wave
// cosine table (built at elaboration) plus symmetry yields W_N^k; on start
// the per-stage sequence k = j * (N >> (s+1)) is streamed over valid/ready.
module twiddle_seq_gen #(
  parameter int N     = 64,
  parameter int WIDTH = 9,
  parameter int FRAC  = 8,
  localparam int LOG2N = $clog2(N),
  localparam int SW    = ($clog2(LOG2N) < 1) ? 1 : $clog2(LOG2N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [SW-1:0]  stage,
  input  logic           inverse,
  twiddle_seq_gen_if.master tw,
  output logic           busy,
  output logic           done,
  output logic           err
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam int  KQ = N / 4;
  localparam int  TW = WIDTH + 1;
  localparam int  FW = WIDTH + 2;
  localparam real PI = 3.14159265358979323846;

  localparam logic signed [FW-1:0] SAT_HI = FW'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [FW-1:0] SAT_LO = FW'(-(1 << (WIDTH - 1)));

  function automatic real cos_taylor(input real x);
    real term;
    real sum;
    term = 1.0;
    sum  = 1.0;
    for (int unsigned n = 1; n < 24; n++) begin
      term = -term * x * x / (real'(2 * n - 1) * real'(2 * n));
      sum  = sum + term;
    end
    return sum;
  endfunction

  // C[i] = round-half-away-from-zero(2^FRAC * cos(2*pi*i/N)), i = 0..N/4
  function automatic logic [(KQ+1)*TW-1:0] build_table();
    logic [(KQ+1)*TW-1:0] v;
    real c;
    int  r;
    v = '0;
    for (int unsigned i = 0; i <= KQ; i++) begin
      c = real'(1 << FRAC) * cos_taylor(2.0 * PI * real'(i) / real'(N));
      if (c >= 0.0) r = $rtoi(c + 0.5);
      else          r = -$rtoi(0.5 - c);
      v[i*TW +: TW] = TW'(r);
    end
    return v;
  endfunction

  localparam logic [(KQ+1)*TW-1:0] C_FLAT = build_table();

  function automatic logic signed [FW-1:0] tab(input int unsigned i);
    logic [TW-1:0] t;
    t = C_FLAT[i*TW +: TW];
    return FW'($signed(t));
  endfunction

  function automatic logic [WIDTH-1:0] sat(input logic signed [FW-1:0] v);
    logic signed [FW-1:0] c;
    c = v;
    if (v > SAT_HI) c = SAT_HI;
    if (v < SAT_LO) c = SAT_LO;
    return c[WIDTH-1:0];
  endfunction

  state_t             r_state, w_state_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_last,  w_last_nxt;
  logic [WIDTH-1:0]   r_re,    w_re_nxt;
  logic [WIDTH-1:0]   r_im,    w_im_nxt;
  logic [LOG2N-1:0]   r_k,     w_k_nxt;
  logic [LOG2N-1:0]   r_j,     w_j_nxt;
  logic [SW-1:0]      r_stage, w_stage_nxt;
  logic               r_inv,   w_inv_nxt;
  logic               r_done,  w_done_nxt;
  logic               r_err,   w_err_nxt;

  logic [SW-1:0]         w_sel_stage;
  logic                  w_sel_inv;
  logic [LOG2N-1:0]      w_sel_j;
  logic [SW-1:0]         w_shamt;
  logic [LOG2N-1:0]      w_sel_k;
  logic [LOG2N-1:0]      w_jmax;
  logic                  w_sel_last;
  int unsigned           w_kq;
  logic signed [FW-1:0]  w_re_f;
  logic signed [FW-1:0]  w_im_f;
  logic [WIDTH-1:0]      w_beat_re;
  logic [WIDTH-1:0]      w_beat_im;

  // Candidate next beat: the j=0 beat of the commanded stage while idle,
  // otherwise beat j+1 of the latched stage.
  always_comb begin
    w_sel_stage = (r_state == S_IDLE) ? stage   : r_stage;
    w_sel_inv   = (r_state == S_IDLE) ? inverse : r_inv;
    w_sel_j     = (r_state == S_IDLE) ? '0      : r_j + 1'b1;
    w_shamt     = SW'(LOG2N - 1) - w_sel_stage;
    w_sel_k     = w_sel_j << w_shamt;
    w_jmax      = (LOG2N'(1) << w_sel_stage) - 1'b1;
    w_sel_last  = (w_sel_j == w_jmax);
    w_kq        = 32'(w_sel_k);
    if (w_kq <= KQ) begin
      w_re_f = tab(w_kq);
      w_im_f = -tab(KQ - w_kq);
    end else begin
      w_re_f = -tab(N / 2 - w_kq);
      w_im_f = -tab(w_kq - KQ);
    end
    if (w_sel_inv) w_im_f = -w_im_f;
    w_beat_re = sat(w_re_f);
    w_beat_im = sat(w_im_f);
  end

  // Sequencer next-state and registered-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_last_nxt  = r_last;
    w_re_nxt    = r_re;
    w_im_nxt    = r_im;
    w_k_nxt     = r_k;
    w_j_nxt     = r_j;
    w_stage_nxt = r_stage;
    w_inv_nxt   = r_inv;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (32'(stage) < LOG2N) begin
            w_state_nxt = S_RUN;
            w_stage_nxt = stage;
            w_inv_nxt   = inverse;
            w_valid_nxt = 1'b1;
            w_j_nxt     = w_sel_j;
            w_k_nxt     = w_sel_k;
            w_re_nxt    = w_beat_re;
            w_im_nxt    = w_beat_im;
            w_last_nxt  = w_sel_last;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (r_valid && tw.out_ready) begin
          if (r_last) begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_re_nxt    = '0;
            w_im_nxt    = '0;
            w_k_nxt     = '0;
            w_j_nxt     = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_j_nxt    = w_sel_j;
            w_k_nxt    = w_sel_k;
            w_re_nxt   = w_beat_re;
            w_im_nxt   = w_beat_im;
            w_last_nxt = w_sel_last;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_re    <= '0;
      r_im    <= '0;
      r_k     <= '0;
      r_j     <= '0;
      r_stage <= '0;
      r_inv   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
      r_re    <= w_re_nxt;
      r_im    <= w_im_nxt;
      r_k     <= w_k_nxt;
      r_j     <= w_j_nxt;
      r_stage <= w_stage_nxt;
      r_inv   <= w_inv_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign tw.out_valid = r_valid;
  assign tw.out_re    = r_re;
  assign tw.out_im    = r_im;
  assign tw.out_k     = r_k;
  assign tw.out_last  = r_last;
  assign busy         = (r_state == S_RUN);
  assign done         = r_done;
  assign err          = r_err;

endmodule
